// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline flow controller.
// Stage indices name the classic five-stage layout; wider pipelines
// simply use more numeric stages beyond STAGE_WB.
package hazard_ctrl_pkg;

    localparam int STAGE_IF           = 0;
    localparam int STAGE_ID           = 1;
    localparam int STAGE_EX           = 2;
    localparam int STAGE_MEM          = 3;
    localparam int STAGE_WB           = 4;
    localparam int DEFAULT_NUM_STAGES = 5;

    // Per-stage occupancy: occ = slot holds something, val = it is not squashed.
    typedef struct packed {
        logic occ;
        logic val;
    } slot_state_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage's occupancy/validity flop pair.
// enter has priority over leave so a slot can release and refill in the
// same cycle; a staying occupant loses its valid bit when squashed.
module pipe_stage_slot
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enter,
    input  logic        leave,
    input  logic        enter_val,
    input  logic        squash,
    output slot_state_t state
);

    // Next-state: refill, drain, or hold (with optional squash).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (enter) begin
            state.occ <= 1'b1;
            state.val <= enter_val;
        end else if (leave) begin
            state <= '0;
        end else begin
            state.val <= state.val & ~squash;
        end
    end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// N-stage pipeline flow controller: tracks per-stage occupancy/validity,
// produces pipeline-register load strobes, applies a hazard stall at one
// stage, squashes younger work on a redirect and counts retirements.
module pipeline_flow_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int STALL_STAGE = STAGE_ID,
    parameter int CNT_W       = 32,
    parameter int IDX_W       = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    input  logic                  hazard_i,
    input  logic                  redirect_i,
    input  logic [IDX_W-1:0]      redirect_stage_i,
    output logic [NUM_STAGES-1:0] busy_o,
    output logic [NUM_STAGES-1:0] valid_o,
    output logic [NUM_STAGES-1:0] req_o,
    output logic [NUM_STAGES-1:0] load_o,
    output logic                  retire_o,
    output logic [CNT_W-1:0]      retire_count_o
);

    slot_state_t [NUM_STAGES-1:0] st;

    logic [NUM_STAGES-1:0] occ;
    logic [NUM_STAGES-1:0] val;
    logic [NUM_STAGES-1:0] done;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] sq_mask;
    logic [NUM_STAGES-1:0] enter;
    logic [NUM_STAGES-1:0] leave;
    logic [NUM_STAGES-1:0] enter_val;
    logic                  flush;

    // Stage completion: squashed occupants past fetch never wait; fetch
    // always waits for imem; a live occupant of the stall stage waits on hazard.
    always_comb begin
        done = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            done[s] = occ[s]
                    & (stage_done_i[s] | (~val[s] & (s != STAGE_IF)))
                    & ~((s == STALL_STAGE) & val[s] & hazard_i);
        end
    end

    // Advance chain from retire backwards: a stage moves when done and the
    // next slot is empty or is itself moving this cycle.
    always_comb begin
        logic free;
        adv  = '0;
        free = 1'b1;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            adv[s] = done[s] & free;
            free   = ~occ[s] | (done[s] & free);
        end
    end

    // A redirect only takes effect when its resolving stage is actually
    // advancing; everything older-in-pipe-order (younger instructions) is squashed.
    always_comb begin
        flush   = 1'b0;
        sq_mask = '0;
        for (int s = 1; s < NUM_STAGES; s++) begin
            if (redirect_i && (redirect_stage_i == IDX_W'(s)) && adv[s])
                flush = 1'b1;
        end
        for (int s = 0; s < NUM_STAGES; s++) begin
            sq_mask[s] = flush & (IDX_W'(s) < redirect_stage_i);
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_slot
        if (s == STAGE_IF) begin : g_fetch
            // Fetch is always in flight; a new fetch (or first fetch after
            // reset) is live even under flush since it uses the redirected pc.
            assign enter[s]     = 1'b1;
            assign leave[s]     = adv[s];
            assign enter_val[s] = adv[s] | ~occ[s] | (val[s] & ~sq_mask[s]);
        end else begin : g_body
            assign enter[s]     = adv[s-1];
            assign leave[s]     = adv[s];
            assign enter_val[s] = val[s-1] & ~sq_mask[s-1];
        end

        pipe_stage_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .enter     (enter[s]),
            .leave     (leave[s]),
            .enter_val (enter_val[s]),
            .squash    (sq_mask[s]),
            .state     (st[s])
        );

        assign occ[s] = st[s].occ;
        assign val[s] = st[s].val;
    end

    assign busy_o   = occ;
    assign valid_o  = val;
    assign req_o    = occ & val;
    assign load_o   = adv;
    assign retire_o = adv[NUM_STAGES-1] & val[NUM_STAGES-1];

    // Retire counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst)
            retire_count_o <= '0;
        else if (retire_o)
            retire_count_o <= retire_count_o + CNT_W'(1);
    end

    // A redirect that cannot take effect this cycle is dropped; flag it.
    redirect_ignored: assert property (@(posedge clk) disable iff (rst)
        redirect_i |-> flush);

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed-vector bench: stimulus pushes hand-derived expectations into a
// scoreboard queue; a negedge monitor pops and compares.
module tb_pipeline_flow_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int N   = DEFAULT_NUM_STAGES;
    localparam int IW  = 3;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  stage_done_i = '0;
    logic          hazard_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [IW-1:0] redirect_stage_i = '0;
    logic [N-1:0]  busy_o, valid_o, req_o, load_o;
    logic          retire_o;
    logic [CW-1:0] retire_count_o;

    pipeline_flow_ctrl #(
        .NUM_STAGES  (N),
        .STALL_STAGE (STAGE_ID),
        .CNT_W       (CW),
        .IDX_W       (IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stage_done_i     (stage_done_i),
        .hazard_i         (hazard_i),
        .redirect_i       (redirect_i),
        .redirect_stage_i (redirect_stage_i),
        .busy_o           (busy_o),
        .valid_o          (valid_o),
        .req_o            (req_o),
        .load_o           (load_o),
        .retire_o         (retire_o),
        .retire_count_o   (retire_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] busy;
        logic [4:0] valid;
        logic [4:0] load;
        logic       ret;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = -1;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("busy",   e.cyc, 32'(busy_o),         32'(e.busy));
            chk("valid",  e.cyc, 32'(valid_o),        32'(e.valid));
            chk("req",    e.cyc, 32'(req_o),          32'(e.busy & e.valid));
            chk("load",   e.cyc, 32'(load_o),         32'(e.load));
            chk("retire", e.cyc, 32'(retire_o),       32'(e.ret));
            chk("count",  e.cyc, 32'(retire_count_o), 32'(e.cnt));
        end
    end

    task automatic step(input logic r, input logic [4:0] d, input logic h,
                        input logic rd, input logic [2:0] rs, input bit chk_en,
                        input logic [4:0] eb, input logic [4:0] ev, input logic [4:0] el,
                        input logic er, input logic [3:0] ec);
        @(posedge clk);
        #1;
        rst              = r;
        stage_done_i     = d;
        hazard_i         = h;
        redirect_i       = rd;
        redirect_stage_i = rs;
        cyc_no++;
        if (chk_en) begin
            exp_t e;
            e.cyc = cyc_no; e.busy = eb; e.valid = ev; e.load = el; e.ret = er; e.cnt = ec;
            sb.push_back(e);
        end
    endtask

    // Fill from reset with every stage completing: stage k fills on cycle k,
    // first retire on cycle 5, then one per cycle.
    task automatic ramp(input int kmax);
        for (int k = 0; k <= kmax; k++) begin
            int         n;
            logic [4:0] m;
            n = (k < 5) ? k : 5;
            m = 5'((1 << n) - 1);
            step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, m, m, m, (k >= 5),
                 (k >= 5) ? 4'((k - 5) % 16) : 4'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // reset state
        step(1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0, 4'd0);
        // fill and steady flow, count 10 shown on cycle 15
        ramp(15);
        // mem stage not done for 3 cycles
        step(1'b0, 5'b10111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b11111, 5'b10000, 1'b1, 4'd11);
        step(1'b0, 5'b10111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b01111, 5'b01111, 5'b00000, 1'b0, 4'd12);
        step(1'b0, 5'b10111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b01111, 5'b01111, 5'b00000, 1'b0, 4'd12);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b01111, 5'b01111, 5'b01111, 1'b0, 4'd12);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1, 4'd12);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1, 4'd13);
        // hazard for 2 cycles at stage 1; bubble opens at stage 2; count wraps
        step(1'b0, 5'b11111, 1'b1, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b11111, 5'b11100, 1'b1, 4'd14);
        step(1'b0, 5'b11111, 1'b1, 1'b0, 3'd0, 1'b1, 5'b11011, 5'b11011, 5'b11000, 1'b1, 4'd15);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b10011, 5'b10011, 5'b10011, 1'b1, 4'd0);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b00111, 5'b00111, 5'b00111, 1'b0, 4'd1);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b01111, 5'b01111, 5'b01111, 1'b0, 4'd1);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1, 4'd1);
        // redirect resolved in stage 2: stages 1,2 become bubbles, fresh fetch in 0
        step(1'b0, 5'b11111, 1'b0, 1'b1, 3'd2, 1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1, 4'd2);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b11001, 5'b11111, 1'b1, 4'd3);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b10011, 5'b11111, 1'b1, 4'd4);
        // squashed occupant in stage 3 advances despite mem not done, no request
        step(1'b0, 5'b10111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b00111, 5'b11111, 1'b0, 4'd5);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b01111, 5'b11111, 1'b0, 4'd5);
        step(1'b0, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1, 4'd5);
        // mid-stream reset, then 17 retires wrap the 4-bit counter to 1
        step(1'b1, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0, 4'd0);
        ramp(22);

        @(posedge clk);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
